// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display drivers: active-low digit patterns and FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // gfedcba, 0 = segment lit
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ENCODE
    } state_t;

endpackage

// File: rtl/seg7_digit_encoder.sv
// Combinational 4-bit BCD digit to active-low 7-segment pattern.
// Codes 10..15 never come out of the converter; they map to a blank digit.
module seg7_digit_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bin_display.sv
// Binary to multi-digit 7-segment driver using bit-serial double dabble.
// Latency: WIDTH+1 cycles from accepting start to done; start is dropped while busy.
module seg7_bin_display
    import seg7_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIGITS     = 8,
    parameter int LEAD_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_t              state;
    logic [WIDTH-1:0]    shift_q;
    logic [BW-1:0]       bcd_q;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       cnt_q;
    logic                ovf_acc;
    logic [7*DIGITS-1:0] seg_enc;
    logic [7*DIGITS-1:0] seg_nxt;
    logic [DIGITS-1:0]   blank;

    assign busy = (state != ST_IDLE);

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        seg7_digit_encoder u_enc (
            .bcd (bcd_q[4*k +: 4]),
            .seg (seg_enc[7*k +: 7])
        );
    end

    // Walk down from the top digit; a digit is blanked while nothing nonzero has been seen yet.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen     = seen | (bcd_q[4*k +: 4] != 4'd0);
            blank[k] = (LEAD_BLANK != 0) && (k != 0) && !seen;
        end
    end

    always_comb begin
        seg_nxt = seg_enc;
        for (int k = 0; k < DIGITS; k++) begin
            if (ovf_acc) begin
                seg_nxt[7*k +: 7] = SEG_DASH;
            end else if (blank[k]) begin
                seg_nxt[7*k +: 7] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_acc  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seg_out  <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_q <= value_in;
                        bcd_q   <= '0;
                        ovf_acc <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A carry out of the top digit means the value needs more digits than we have.
                    bcd_q   <= {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
                    shift_q <= shift_q << 1;
                    if (bcd_adj[BW-1]) begin
                        ovf_acc <= 1'b1;
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    seg_out  <= seg_nxt;
                    overflow <= ovf_acc;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
